// File: rtl/layer_sequencer.sv
// layer_sequencer: launches NUM_STAGES compute stages of the digit-recognition
// datapath one after another, with a programmable start delay, optional
// preemption by a new start, a per-stage watchdog and frame status pulses.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   start       in   level request to run a frame
//   done        in   [NUM_STAGES] per-stage completion level
//   go          out  [NUM_STAGES] one-cycle launch pulse for the current stage
//   stage       out  [SW] index of the current stage (0 when idle)
//   busy        out  high whenever a frame is in progress
//   frame_done  out  one-cycle pulse after the last stage completes
//   error       out  one-cycle pulse when the watchdog expires
module layer_sequencer #(
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned START_DELAY = 2,
    parameter int unsigned PREEMPT     = 1,
    parameter int unsigned TIMEOUT     = 0,
    localparam int unsigned SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int unsigned CNT_MAX    = (START_DELAY > TIMEOUT) ? START_DELAY : TIMEOUT,
    localparam int unsigned CW         = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_STAGES-1:0] done,
    output logic [NUM_STAGES-1:0] go,
    output logic [SW-1:0]         stage,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_GO    = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [SW-1:0] LAST_STAGE   = SW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] DELAY_LAST   = CW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    // With no start delay a new frame launches stage 0 straight away.
    localparam state_t        LAUNCH       = (START_DELAY > 0) ? S_DELAY : S_GO;

    state_t          r_state;
    logic [SW-1:0]   r_stage;
    logic [CW-1:0]   r_cnt;
    logic            r_frame_done;
    logic            r_error;

    // Only the done bit of the stage being waited on matters.
    logic            w_done_cur;
    assign w_done_cur = done[r_stage];

    // Sequencer state, stage index, shared delay/watchdog counter and pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_stage      <= '0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= LAUNCH;
                        r_stage <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_state <= S_GO;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GO: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (w_done_cur) begin
                        if (r_stage != LAST_STAGE) begin
                            if ((PREEMPT != 0) && start) begin
                                // New frame request overrides the one in flight.
                                r_state <= LAUNCH;
                                r_stage <= '0;
                                r_cnt   <= '0;
                            end else begin
                                r_state <= S_GO;
                                r_stage <= r_stage + SW'(1);
                            end
                        end else begin
                            r_state      <= S_IDLE;
                            r_stage      <= '0;
                            r_frame_done <= 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (r_cnt == TIMEOUT_LAST)) begin
                        r_state <= S_IDLE;
                        r_stage <= '0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stage <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    assign go         = (r_state == S_GO) ? (NUM_STAGES'(1) << r_stage) : '0;
    assign stage      = r_stage;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign error      = r_error;

endmodule
